// File: rtl/inst_sram_like_resp_if.sv
// rtl/inst_sram_like_resp_if.sv - SRAM-like request/response bus (req/addr_ok/data_ok)
interface inst_sram_like_resp_if;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    logic        data_ok;
    logic [31:0] rdata;

    modport master (
        output req, wr, size, wstrb, addr, wdata,
        input  addr_ok, data_ok, rdata
    );

    modport slave (
        input  req, wr, size, wstrb, addr, wdata,
        output addr_ok, data_ok, rdata
    );
endinterface

// File: rtl/inst_sram_like_resp.sv
// rtl/inst_sram_like_resp.sv - SRAM-like responder: accepts requests, drives a sync RAM, returns in-order data_ok
module inst_sram_like_resp #(
    parameter int MAX_OUTSTANDING = 2,
    parameter int DATA_LAT        = 1,
    parameter int MEM_AW          = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    inst_sram_like_resp_if.slave bus,
    input  logic                 addr_stall,
    input  logic                 data_stall,
    output logic                 ram_en,
    output logic [3:0]           ram_we,
    output logic [MEM_AW-1:0]    ram_addr,
    output logic [31:0]          ram_wdata,
    input  logic [31:0]          ram_rdata
);
    localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_OUTSTANDING);
    localparam logic [PW-1:0] LAST_IDX = PW'(MAX_OUTSTANDING - 1);
    localparam logic [3:0]    LAT      = 4'(DATA_LAT);

    logic [CW-1:0]              count;
    logic [PW-1:0]              head;
    logic [PW-1:0]              tail;
    logic [MAX_OUTSTANDING-1:0] ent_v;
    logic [MAX_OUTSTANDING-1:0] ent_cap;
    logic                       ent_wr   [MAX_OUTSTANDING];
    logic [31:0]                ent_data [MAX_OUTSTANDING];
    logic [2:0]                 ent_age  [MAX_OUTSTANDING];
    logic                       cap_pend;
    logic [PW-1:0]              cap_idx;

    logic        acc;
    logic        pop;
    logic        head_cap_now;
    logic [3:0]  head_age1;
    logic        head_ready;
    logic [31:0] head_data;
    logic        unused_bits;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_IDX) ? '0 : p + 1'b1;
    endfunction

    assign bus.addr_ok = !reset && !addr_stall && (count < MAX_CNT);
    assign acc         = bus.req && bus.addr_ok;

    assign ram_en    = acc;
    assign ram_we    = (acc && bus.wr) ? bus.wstrb : 4'b0;
    assign ram_addr  = bus.addr[MEM_AW+1:2];
    assign ram_wdata = bus.wdata;

    // The RAM word for the newest entry is only on ram_rdata during the cycle after
    // acceptance; forward it so a head entry can respond in that same cycle.
    assign head_cap_now = cap_pend && (cap_idx == head);
    assign head_age1    = {1'b0, ent_age[head]} + 4'd1;
    assign head_ready   = ent_v[head] && (ent_cap[head] || head_cap_now) && (head_age1 >= LAT);
    assign head_data    = ent_cap[head] ? ent_data[head] : (ent_wr[head] ? 32'h0 : ram_rdata);

    assign pop          = head_ready && !data_stall;
    assign bus.data_ok  = pop;
    assign bus.rdata    = pop ? head_data : 32'h0;

    assign unused_bits = ^{bus.size, bus.addr[31:MEM_AW+2], bus.addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count    <= '0;
            head     <= '0;
            tail     <= '0;
            ent_v    <= '0;
            ent_cap  <= '0;
            cap_pend <= 1'b0;
            cap_idx  <= '0;
        end else begin
            if (pop) begin
                ent_v[head] <= 1'b0;
                head        <= ptr_next(head);
            end
            if (cap_pend) begin
                ent_cap[cap_idx] <= 1'b1;
            end
            if (acc) begin
                ent_v[tail]   <= 1'b1;
                ent_cap[tail] <= 1'b0;
                tail          <= ptr_next(tail);
            end
            cap_pend <= acc;
            cap_idx  <= tail;
            case ({acc, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < MAX_OUTSTANDING; i++) begin
            if (ent_age[i] != 3'd7) begin
                ent_age[i] <= ent_age[i] + 3'd1;
            end
        end
        if (cap_pend) begin
            ent_data[cap_idx] <= ent_wr[cap_idx] ? 32'h0 : ram_rdata;
        end
        if (acc) begin
            ent_age[tail]  <= 3'd0;
            ent_wr[tail]   <= bus.wr;
            ent_data[tail] <= 32'h0;
        end
    end
endmodule

// File: tb/tb_inst_sram_like_resp.sv
// tb/tb_inst_sram_like_resp.sv - directed self-checking bench for inst_sram_like_resp
module tb_inst_sram_like_resp;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic as1, ds1;
    logic        ram_en1, ram_en2;
    logic [3:0]  ram_we1, ram_we2;
    logic [15:0] ram_addr1, ram_addr2;
    logic [31:0] ram_wdata1, ram_wdata2, ram_rdata1, ram_rdata2;

    logic        bd_we;
    logic        bd_sel;
    logic [9:0]  bd_idx;
    logic [31:0] bd_val;

    logic [31:0] mem1 [0:1023];
    logic [31:0] mem2 [0:1023];

    int checks   = 0;
    int failures = 0;

    inst_sram_like_resp_if b1();
    inst_sram_like_resp_if b2();

    inst_sram_like_resp #(.MAX_OUTSTANDING(2), .DATA_LAT(1), .MEM_AW(16)) dut (
        .clk(clk), .reset(reset), .bus(b1), .addr_stall(as1), .data_stall(ds1),
        .ram_en(ram_en1), .ram_we(ram_we1), .ram_addr(ram_addr1),
        .ram_wdata(ram_wdata1), .ram_rdata(ram_rdata1)
    );

    inst_sram_like_resp #(.MAX_OUTSTANDING(2), .DATA_LAT(3), .MEM_AW(16)) dut_lat3 (
        .clk(clk), .reset(reset), .bus(b2), .addr_stall(1'b0), .data_stall(1'b0),
        .ram_en(ram_en2), .ram_we(ram_we2), .ram_addr(ram_addr2),
        .ram_wdata(ram_wdata2), .ram_rdata(ram_rdata2)
    );

    always @(posedge clk) begin
        if (bd_we && !bd_sel) begin
            mem1[bd_idx] <= bd_val;
        end else if (ram_en1) begin
            ram_rdata1 <= mem1[ram_addr1[9:0]];
            for (int k = 0; k < 4; k++)
                if (ram_we1[k]) mem1[ram_addr1[9:0]][8*k +: 8] <= ram_wdata1[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        if (bd_we && bd_sel) begin
            mem2[bd_idx] <= bd_val;
        end else if (ram_en2) begin
            ram_rdata2 <= mem2[ram_addr2[9:0]];
            for (int k = 0; k < 4; k++)
                if (ram_we2[k]) mem2[ram_addr2[9:0]][8*k +: 8] <= ram_wdata2[8*k +: 8];
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic poke(input logic sel, input logic [9:0] idx, input logic [31:0] val);
        bd_sel = sel;
        bd_idx = idx;
        bd_val = val;
        bd_we  = 1'b1;
        step();
        bd_we  = 1'b0;
    endtask

    logic last_acc;

    initial begin
        reset = 1'b1;
        as1 = 1'b0; ds1 = 1'b0;
        bd_we = 1'b0; bd_sel = 1'b0; bd_idx = '0; bd_val = '0;
        b1.req = 1'b0; b1.wr = 1'b0; b1.size = 2'd2; b1.wstrb = 4'h0; b1.addr = '0; b1.wdata = '0;
        b2.req = 1'b0; b2.wr = 1'b0; b2.size = 2'd2; b2.wstrb = 4'h0; b2.addr = '0; b2.wdata = '0;

        poke(1'b0, 10'h100, 32'h02800C00);
        poke(1'b0, 10'd0, 32'd1);
        poke(1'b0, 10'd1, 32'd2);
        poke(1'b0, 10'd2, 32'd3);
        poke(1'b0, 10'd3, 32'd4);
        poke(1'b1, 10'd4, 32'h5A5A0001);

        // In reset with a write request presented: nothing may leak out.
        b1.req = 1'b1; b1.wr = 1'b1; b1.wstrb = 4'hF; b1.addr = 32'h1C000400;
        sample();
        check_eq("rst_addr_ok", 32'(b1.addr_ok), 32'd0);
        check_eq("rst_data_ok", 32'(b1.data_ok), 32'd0);
        check_eq("rst_rdata",   b1.rdata, 32'h0);
        check_eq("rst_ram_en",  32'(ram_en1), 32'd0);
        check_eq("rst_ram_we",  32'(ram_we1), 32'd0);

        // First read right out of reset
        step();
        reset = 1'b0; b1.wr = 1'b0; b1.wstrb = 4'h0;
        sample();
        check_eq("t1_addr_ok",  32'(b1.addr_ok), 32'd1);
        check_eq("t1_ram_addr", 32'(ram_addr1), 32'h0100);
        step();
        b1.req = 1'b0;
        sample();
        check_eq("t1_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("t1_rdata",   b1.rdata, 32'h02800C00);
        for (int i = 0; i < 3; i++) begin
            step(); sample();
            check_eq("t1_no_extra", 32'(b1.data_ok), 32'd0);
        end

        // Four back-to-back reads through a 2-deep queue
        for (int i = 0; i < 5; i++) begin
            step();
            b1.req  = (i < 4);
            b1.addr = 32'(4 * i);
            sample();
            if (i < 4) check_eq("b2b_addr_ok", 32'(b1.addr_ok), 32'd1);
            if (i > 0) begin
                check_eq("b2b_data_ok", 32'(b1.data_ok), 32'd1);
                check_eq("b2b_rdata",   b1.rdata, 32'(i));
            end
        end
        step(); b1.req = 1'b0;
        sample();
        check_eq("b2b_idle", 32'(b1.data_ok), 32'd0);

        // Data-phase stall fills the queue, then drains in order
        last_acc = 1'b0;
        for (int s = 0; s < 5; s++) begin
            step();
            if (s == 0) begin
                ds1 = 1'b1; b1.req = 1'b1; b1.addr = 32'h0;
            end else if (last_acc) begin
                b1.addr = b1.addr + 32'd4;
            end
            sample();
            last_acc = b1.req & b1.addr_ok;
            check_eq("full_addr_ok", 32'(b1.addr_ok), (s < 2) ? 32'd1 : 32'd0);
            check_eq("full_data_ok", 32'(b1.data_ok), 32'd0);
        end
        step(); ds1 = 1'b0;
        sample();
        check_eq("drain0_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("drain0_rdata",   b1.rdata, 32'd1);
        check_eq("drain0_addr_ok", 32'(b1.addr_ok), 32'd0);
        step();
        sample();
        check_eq("drain1_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("drain1_rdata",   b1.rdata, 32'd2);
        check_eq("drain1_addr_ok", 32'(b1.addr_ok), 32'd1);
        step(); b1.req = 1'b0;
        sample();
        check_eq("drain2_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("drain2_rdata",   b1.rdata, 32'd3);
        step(); sample();
        check_eq("drain_idle", 32'(b1.data_ok), 32'd0);

        // Partial write, then read back the merged word
        poke(1'b0, 10'd2, 32'h11223344);
        b1.req = 1'b1; b1.wr = 1'b1; b1.addr = 32'h8; b1.wstrb = 4'b0011; b1.wdata = 32'hAABBCCDD;
        sample();
        check_eq("wr_addr_ok", 32'(b1.addr_ok), 32'd1);
        check_eq("wr_ram_we",  32'(ram_we1), 32'h3);
        step();
        b1.wr = 1'b0; b1.wstrb = 4'h0;
        sample();
        check_eq("wr_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("wr_rdata",   b1.rdata, 32'h0);
        check_eq("rd_ram_we",  32'(ram_we1), 32'h0);
        step(); b1.req = 1'b0;
        sample();
        check_eq("rd_data_ok", 32'(b1.data_ok), 32'd1);
        check_eq("rd_rdata",   b1.rdata, 32'h1122CCDD);

        // Reset with two requests outstanding
        step(); ds1 = 1'b1; b1.req = 1'b1; b1.addr = 32'h0;
        sample();
        step(); sample();
        step(); b1.req = 1'b0; reset = 1'b1;
        sample();
        check_eq("rst2_data_ok", 32'(b1.data_ok), 32'd0);
        check_eq("rst2_addr_ok", 32'(b1.addr_ok), 32'd0);
        check_eq("rst2_ram_en",  32'(ram_en1), 32'd0);
        step(); ds1 = 1'b0;
        sample();
        check_eq("rst2_hold", 32'(b1.data_ok), 32'd0);
        step(); reset = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) step();
            sample();
            check_eq("rst2_no_stale", 32'(b1.data_ok), 32'd0);
            check_eq("rst2_addr_ok_free", 32'(b1.addr_ok), 32'd1);
        end

        // DATA_LAT = 3 instance: response exactly three cycles after acceptance
        step(); b2.req = 1'b1; b2.addr = 32'h10;
        sample();
        check_eq("lat3_addr_ok", 32'(b2.addr_ok), 32'd1);
        step(); b2.req = 1'b0;
        sample();
        check_eq("lat3_t1", 32'(b2.data_ok), 32'd0);
        step(); sample();
        check_eq("lat3_t2", 32'(b2.data_ok), 32'd0);
        step(); sample();
        check_eq("lat3_t3_data_ok", 32'(b2.data_ok), 32'd1);
        check_eq("lat3_t3_rdata",   b2.rdata, 32'h5A5A0001);
        step(); sample();
        check_eq("lat3_t4", 32'(b2.data_ok), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/inst_sram_like_resp.md
# inst_sram_like_resp

Responder end of the SRAM-like request/response protocol (req/addr_ok/data_ok) driven by the fetch and memory stages. It accepts address-phase handshakes, issues each accepted request to a word-addressed synchronous RAM, and returns one in-order `data_ok` pulse with `rdata` per accepted request after a configurable latency. It serves as the inst/data-side slave in the SoC-lite and unit benches. Two stall inputs let a bench apply address-phase and data-phase backpressure.

## Interface
Parameters:
- `MAX_OUTSTANDING`, default 2: accepted-but-unanswered requests held (1..4).
- `DATA_LAT`, default 1: minimum cycles from acceptance to `data_ok` (1..7).
- `MEM_AW`, default 16: RAM word-address width.

Ports:
- `clk` in 1: the single clock.
- `reset` in 1: asynchronous, active-high reset.
- `req` in 1: request valid, from the master.
- `wr` in 1: 1 = write, 0 = read.
- `size` in 2: access size. Carried with the request; not used for addressing.
- `wstrb` in 4: write byte enables.
- `addr` in 32: byte address.
- `wdata` in 32: write data.
- `addr_ok` out 1: request accepted this cycle when `req & addr_ok`.
- `data_ok` out 1: one-cycle pulse, response for the oldest outstanding request.
- `rdata` out 32: read data, valid while `data_ok` = 1.
- `addr_stall` in 1: bench backpressure; forces `addr_ok` = 0.
- `data_stall` in 1: bench backpressure; forces `data_ok` = 0.
- `ram_en` out 1: RAM access strobe.
- `ram_we` out 4: RAM byte write enables.
- `ram_addr` out MEM_AW: RAM word address, `addr[MEM_AW+1:2]`.
- `ram_wdata` out 32: RAM write data.
- `ram_rdata` in 32: RAM read data, valid 1 cycle after `ram_en`.

## Operation
- `addr_ok = !reset_state & !addr_stall & (count < MAX_OUTSTANDING)`.
  - `count` is a registered value, so a `data_ok` in the same cycle does not free a slot until the next cycle.
  - `addr_ok` has no combinational dependence on `req`, `addr` or `wr`.
- Accept condition: `acc = req & addr_ok`.
- On `acc`:
  - `ram_en` = 1.
  - `ram_we` = `wr ? wstrb : 4'b0`.
  - `ram_addr` and `ram_wdata` pass through combinationally.
  - A queue entry {wr, data, age = 0, captured = 0} is pushed at the tail.
- The cycle after `acc`, a read entry captures `ram_rdata` into its data field. A write entry stores 0.
- Each cycle, every entry's age increments, saturating at 7.
- Response: `data_ok` = 1 when the head entry exists, head.age ≥ DATA_LAT, head.captured = 1, and `data_stall` = 0. The head is popped on that same edge.
- `rdata` = head.data while `data_ok` = 1; otherwise 0.
- Responses are strictly in acceptance order. There is exactly one `data_ok` per accepted request, for reads and writes alike.
- The responder never drops a response. Discarding responses after a pipeline cancel is the master's job.
- Queue storage is a circular buffer with head/tail pointers of width `clog2(MAX_OUTSTANDING)`, wrapping modulo MAX_OUTSTANDING. `count` is one bit wider than the pointers.
- Simultaneous push and pop: `count` is unchanged and both pointers advance.
- Misaligned `addr[1:0]` is ignored; the word is accessed. Alignment faults are checked by the master.

## Timing
- Reset (asynchronous, active-high):
  - `count`, pointers and all entry valid bits are cleared.
  - `addr_ok` = 0, `data_ok` = 0, `rdata` = 0, `ram_en` = 0, `ram_we` = 0.
  - Requests in flight are discarded and no response is ever issued for them.
  - `addr_ok` may assert in the first cycle after reset deasserts.
- Best-case read with DATA_LAT = 1 and no stalls: `acc` in cycle T, `data_ok` and `rdata` in cycle T+1.
- General latency: `data_ok` in cycle T + max(DATA_LAT, 1) + (cycles of `data_stall`) + (cycles waiting behind older entries).
- Throughput: one accept per cycle and one response per cycle. With MAX_OUTSTANDING ≥ 2 and DATA_LAT = 1, the steady state is back-to-back accepts and back-to-back `data_ok`.
- Full: `count == MAX_OUTSTANDING` holds `addr_ok` = 0 until the cycle after a pop.
- Empty: `data_ok` = 0 and `rdata` = 0.
- `addr_stall` and `data_stall` take effect in the same cycle they are asserted.

## Test plan
- Reset release, RAM preloaded word 0x100 = 0x02800C00, `req` = 1, `addr` = 0x1C000400 (MEM_AW = 16). Required: `addr_ok` = 1 in cycle 1, then `data_ok` = 1 with `rdata` = 0x02800C00 in cycle 2. No other `data_ok` pulses.
- MAX_OUTSTANDING = 2, `data_stall` = 1 for 5 cycles, `req` held high. Required: exactly 2 accepts, then `addr_ok` = 0 while full. After the stall drops, the two `data_ok` pulses arrive in order on consecutive cycles, and `addr_ok` reasserts the cycle after the first pop.
- Write `addr` = 0x8, `wstrb` = 4'b0011, `wdata` = 0xAABBCCDD over old word 0x11223344, then read 0x8. Required: the write returns `data_ok` with `rdata` = 0, and the read returns 0x1122CCDD.
- DATA_LAT = 3, a read accepted in cycle T. Required: `data_ok` first in cycle T+3.
- Four back-to-back reads to addresses 0, 4, 8, C holding 1, 2, 3, 4 (DATA_LAT = 1, MAX_OUTSTANDING = 2). Required: `data_ok` on 4 consecutive cycles with `rdata` 1, 2, 3, 4, and the pointers wrap with no lost or duplicated response.
- Reset asserted with 2 requests outstanding. Required: `data_ok` stays 0 immediately and through reset, and no stale response appears after release.
